int_ctrl: RTL and testbench



---
 rtl/int_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_int_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronized lines, edge/level pending, IDLE/ASSERT/HOLDOFF handshake.
// Optional compare timer on line 5 enabled by defining INT_CTRL_TIMER_EN.
module int_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_src,
    input  logic        cfg_wen,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        ext_int_response,
    output logic [5:0]  ext_int,
    output logic [5:0]  pend,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLDOFF
    } state_t;

    localparam logic [7:0] HO_LAST = 8'(HOLDOFF_CYC - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0][5:0] r_sync;
    logic [5:0] r_prev;
    logic [5:0] r_mask;
    logic [5:0] r_edge;
    logic [5:0] r_pend;
    logic [5:0] r_ext;
    logic [7:0] r_cnt;

    logic [5:0] w_sync;
    logic [5:0] w_rise;
    logic [5:0] w_set;
    logic [5:0] w_edge_eff;
    logic [5:0] w_clr;
    logic [5:0] w_pend_nxt;
    logic [5:0] w_req;
    logic [5:0] w_ext_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_ack;
    logic       w_wr_mask;
    logic       w_wr_edge;
    logic       w_wr_w1c;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sync & ~r_prev;
    assign w_wr_mask = cfg_wen && (cfg_addr == 2'd0);
    assign w_wr_edge = cfg_wen && (cfg_addr == 2'd1);
    assign w_wr_w1c  = cfg_wen && (cfg_addr == 2'd3);
    assign w_ack     = ext_int_response && (r_state == S_ASSERT);
    assign w_req     = r_pend & r_mask;

`ifdef INT_CTRL_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        w_match;
    logic        w_wr_cmp;
    logic        w_unused;

    assign w_wr_cmp   = cfg_wen && (cfg_addr == 2'd2);
    assign w_match    = (r_count == r_cmp);
    // Line 5 is owned by the timer and always behaves as edge type.
    assign w_set      = {w_match, w_rise[4:0]};
    assign w_edge_eff = {1'b1, r_edge[4:0]};
    assign w_unused   = w_rise[5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_cmp   <= 32'hFFFF_FFFF;
        end else begin
            r_count <= r_count + 32'd1;
            if (w_wr_cmp)
                r_cmp <= cfg_wdata;
        end
    end
`else
    logic w_unused;

    assign w_set      = w_rise;
    assign w_edge_eff = r_edge;
    assign w_unused   = ^cfg_wdata[31:6];
`endif

    always_comb begin
        w_clr = '0;
        if (w_wr_w1c)
            w_clr = w_clr | cfg_wdata[5:0];
        if (w_ack)
            w_clr = w_clr | r_ext;
        // Set beats clear; level lines simply track the synchronized input.
        w_pend_nxt = (w_edge_eff & ((r_pend & ~w_clr) | w_set))
                   | (~w_edge_eff & w_sync);
`ifdef INT_CTRL_TIMER_EN
        if (w_wr_cmp)
            w_pend_nxt[5] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
            r_mask <= '0;
            r_edge <= '0;
            r_pend <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_src};
            r_prev <= w_sync;
            r_pend <= w_pend_nxt;
            if (w_wr_mask)
                r_mask <= cfg_wdata[5:0];
            if (w_wr_edge)
                r_edge <= cfg_wdata[5:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ext   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ext   <= w_ext_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ext_nxt   = r_ext;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = S_ASSERT;
                    w_ext_nxt   = w_req;
                end
            end
            S_ASSERT: begin
                if (ext_int_response) begin
                    w_state_nxt = S_HOLDOFF;
                    w_ext_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_wr_mask &&
                             ((r_ext & cfg_wdata[5:0]) == 6'd0)) begin
                    w_state_nxt = S_IDLE;
                    w_ext_nxt   = '0;
                end else begin
                    w_ext_nxt = r_ext | w_req;
                end
            end
            S_HOLDOFF: begin
                // On expiry the IDLE request check happens in the same
                // cycle so ext_int is low for exactly HOLDOFF_CYC cycles.
                if (r_cnt == HO_LAST) begin
                    if (|w_req) begin
                        w_state_nxt = S_ASSERT;
                        w_ext_nxt   = w_req;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ext_nxt   = '0;
            end
        endcase
    end

    assign ext_int = r_ext;
    assign pend    = r_pend;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (SYNC_STAGES=2, HOLDOFF_CYC=4).
// Line 5 scenario depends on whether INT_CTRL_TIMER_EN is defined.
module tb_int_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  irq_src;
    logic        cfg_wen;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        ext_int_response;
    logic [5:0]  ext_int;
    logic [5:0]  pend;
    logic        busy;

    int n_chk;
    int n_pass;

    int_ctrl #(
        .SYNC_STAGES(2),
        .HOLDOFF_CYC(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_src         (irq_src),
        .cfg_wen         (cfg_wen),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .ext_int_response(ext_int_response),
        .ext_int         (ext_int),
        .pend            (pend),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wen   = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick(1);
        cfg_wen   = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL rst_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        n_chk++;
        if (pend !== 6'h00) $display("FAIL rst_pend got=%h exp=%h", pend, 6'h00);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=%b", busy, 1'b0);
        else n_pass++;
        reset = 1'b0;
        irq_src = 6'h3F;
        tick(1);
        irq_src = 6'h00;
        tick(4);
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL rst_masked_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rst_masked_busy got=%b exp=%b", busy, 1'b0);
        else n_pass++;
    endtask

    task automatic test_edge();
        cfg_write(2'd1, 32'h01);
        cfg_write(2'd0, 32'h01);
        irq_src[0] = 1'b1;
        tick(1);
        irq_src[0] = 1'b0;
        tick(2);
        n_chk++;
        if (pend !== 6'h01) $display("FAIL edge_pend got=%h exp=%h", pend, 6'h01);
        else n_pass++;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL edge_early got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        tick(1);
        n_chk++;
        if (ext_int !== 6'h01) $display("FAIL edge_ext got=%h exp=%h", ext_int, 6'h01);
        else n_pass++;
        ext_int_response = 1'b1;
        tick(1);
        ext_int_response = 1'b0;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL edge_ack_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        n_chk++;
        if (pend !== 6'h00) $display("FAIL edge_ack_pend got=%h exp=%h", pend, 6'h00);
        else n_pass++;
        tick(3);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL edge_holdoff_busy got=%b exp=%b", busy, 1'b1);
        else n_pass++;
        tick(1);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL edge_idle_busy got=%b exp=%b", busy, 1'b0);
        else n_pass++;
    endtask

    task automatic test_level();
        cfg_write(2'd1, 32'h00);
        cfg_write(2'd0, 32'h04);
        irq_src[2] = 1'b1;
        tick(3);
        n_chk++;
        if (pend !== 6'h04) $display("FAIL lvl_pend got=%h exp=%h", pend, 6'h04);
        else n_pass++;
        tick(1);
        n_chk++;
        if (ext_int !== 6'h04) $display("FAIL lvl_ext got=%h exp=%h", ext_int, 6'h04);
        else n_pass++;
        ext_int_response = 1'b1;
        tick(1);
        ext_int_response = 1'b0;
        n_chk++;
        if (pend !== 6'h04) $display("FAIL lvl_ack_pend got=%h exp=%h", pend, 6'h04);
        else n_pass++;
        tick(3);
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL lvl_holdoff got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        tick(1);
        n_chk++;
        if (ext_int !== 6'h04) $display("FAIL lvl_reassert got=%h exp=%h", ext_int, 6'h04);
        else n_pass++;
        irq_src[2] = 1'b0;
        tick(2);
        n_chk++;
        if (pend !== 6'h04) $display("FAIL lvl_drop_early got=%h exp=%h", pend, 6'h04);
        else n_pass++;
        tick(1);
        n_chk++;
        if (pend !== 6'h00) $display("FAIL lvl_drop got=%h exp=%h", pend, 6'h00);
        else n_pass++;
        ext_int_response = 1'b1;
        tick(1);
        ext_int_response = 1'b0;
        tick(4);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL lvl_idle got=%b exp=%b", busy, 1'b0);
        else n_pass++;
    endtask

    task automatic test_mask();
        cfg_write(2'd0, 32'h00);
        cfg_write(2'd1, 32'h08);
        irq_src[3] = 1'b1;
        tick(1);
        irq_src[3] = 1'b0;
        tick(4);
        n_chk++;
        if (pend !== 6'h08) $display("FAIL mask_pend got=%h exp=%h", pend, 6'h08);
        else n_pass++;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL mask_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        cfg_write(2'd0, 32'h08);
        tick(1);
        n_chk++;
        if (ext_int !== 6'h08) $display("FAIL mask_unmask got=%h exp=%h", ext_int, 6'h08);
        else n_pass++;
        cfg_write(2'd0, 32'h00);
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL mask_drop_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL mask_drop_busy got=%b exp=%b", busy, 1'b0);
        else n_pass++;
        n_chk++;
        if (pend !== 6'h08) $display("FAIL mask_drop_pend got=%h exp=%h", pend, 6'h08);
        else n_pass++;
        cfg_write(2'd3, 32'h08);
        n_chk++;
        if (pend !== 6'h00) $display("FAIL mask_w1c got=%h exp=%h", pend, 6'h00);
        else n_pass++;
    endtask

    task automatic test_collision();
        cfg_write(2'd1, 32'h02);
        cfg_write(2'd0, 32'h02);
        irq_src[1] = 1'b1;
        tick(1);
        irq_src[1] = 1'b0;
        tick(3);
        n_chk++;
        if (ext_int !== 6'h02) $display("FAIL coll_first got=%h exp=%h", ext_int, 6'h02);
        else n_pass++;
        irq_src[1] = 1'b1;
        tick(1);
        irq_src[1] = 1'b0;
        tick(1);
        ext_int_response = 1'b1;
        tick(1);
        ext_int_response = 1'b0;
        n_chk++;
        if (pend !== 6'h02) $display("FAIL coll_pend got=%h exp=%h", pend, 6'h02);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b1) $display("FAIL coll_busy got=%b exp=%b", busy, 1'b1);
        else n_pass++;
        tick(3);
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL coll_holdoff got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        tick(1);
        n_chk++;
        if (ext_int !== 6'h02) $display("FAIL coll_reassert got=%h exp=%h", ext_int, 6'h02);
        else n_pass++;
    endtask

    task automatic test_line5();
        do_reset();
`ifdef INT_CTRL_TIMER_EN
        cfg_write(2'd0, 32'h20);
        cfg_write(2'd2, 32'd10);
        tick(8);
        n_chk++;
        if (pend !== 6'h00) $display("FAIL tmr_before got=%h exp=%h", pend, 6'h00);
        else n_pass++;
        tick(1);
        n_chk++;
        if (pend !== 6'h20) $display("FAIL tmr_pend got=%h exp=%h", pend, 6'h20);
        else n_pass++;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL tmr_early got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        tick(1);
        n_chk++;
        if (ext_int !== 6'h20) $display("FAIL tmr_ext got=%h exp=%h", ext_int, 6'h20);
        else n_pass++;
        cfg_write(2'd2, 32'd100);
        n_chk++;
        if (pend !== 6'h00) $display("FAIL tmr_clr got=%h exp=%h", pend, 6'h00);
        else n_pass++;
`else
        cfg_write(2'd2, 32'h3F);
        cfg_write(2'd1, 32'h20);
        cfg_write(2'd0, 32'h20);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL l5_addr2 got=%b exp=%b", busy, 1'b0);
        else n_pass++;
        irq_src[5] = 1'b1;
        tick(1);
        irq_src[5] = 1'b0;
        tick(2);
        n_chk++;
        if (pend !== 6'h20) $display("FAIL l5_pend got=%h exp=%h", pend, 6'h20);
        else n_pass++;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL l5_early got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        tick(1);
        n_chk++;
        if (ext_int !== 6'h20) $display("FAIL l5_ext got=%h exp=%h", ext_int, 6'h20);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_holdoff();
        do_reset();
        cfg_write(2'd1, 32'h02);
        cfg_write(2'd0, 32'h02);
        irq_src[1] = 1'b1;
        tick(1);
        irq_src[1] = 1'b0;
        tick(3);
        ext_int_response = 1'b1;
        tick(1);
        ext_int_response = 1'b0;
        irq_src[1] = 1'b1;
        tick(1);
        irq_src[1] = 1'b0;
        tick(2);
        n_chk++;
        if (pend !== 6'h02) $display("FAIL rh_pend_pre got=%h exp=%h", pend, 6'h02);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b1) $display("FAIL rh_busy_pre got=%b exp=%b", busy, 1'b1);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if (pend !== 6'h00) $display("FAIL rh_pend got=%h exp=%h", pend, 6'h00);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rh_busy got=%b exp=%b", busy, 1'b0);
        else n_pass++;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL rh_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
        tick(1);
        reset = 1'b0;
        tick(10);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rh_post_busy got=%b exp=%b", busy, 1'b0);
        else n_pass++;
        n_chk++;
        if (ext_int !== 6'h00) $display("FAIL rh_post_ext got=%h exp=%h", ext_int, 6'h00);
        else n_pass++;
    endtask

    initial begin
        n_chk            = 0;
        n_pass           = 0;
        reset            = 1'b1;
        irq_src          = '0;
        cfg_wen          = 1'b0;
        cfg_addr         = '0;
        cfg_wdata        = '0;
        ext_int_response = 1'b0;
        test_reset();
        test_edge();
        test_level();
        test_mask();
        test_collision();
        test_line5();
        test_reset_holdoff();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
